sram_port0_arbiter: RTL and testbench
=====================================

Name: sram_port0_arbiter

Overview:
- Shares the RW port (port 0) of the 32x256 1rw1r SRAM macro between two requesters (req0, req1) using round-robin arbitration.
- After reset it optionally zero-fills all 256 words before accepting traffic.
- Returns a one-cycle-latency response to the granted requester.
- Sits between the core/DMA fabric and the macro; the macro's port 1 is not touched by this block.

Parameters:
- ADDR_W, 8, word address width (256 words)
- DATA_W, 32, data width
- NUM_WMASKS, 4, byte write-mask width (DATA_W/8)
- INIT_EN, 1, 1 = zero-fill memory after reset; 0 = go straight to RUN

Ports:
- clk  in  1  single clock; drives the macro's clk0 externally
- rst  in  1  asynchronous, active-high reset
- init_done  out  1  high once zero-fill has completed (or immediately with INIT_EN=0)
- reqN_valid  in  1  request valid (N=0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = write, 0 = read
- reqN_wmask  in  NUM_WMASKS  byte enables for writes
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid  out  1  one-cycle response pulse
- rspN_rdata  out  DATA_W  read data, qualified by rspN_valid
- sram_csb0  out  1  active-low chip select
- sram_web0  out  1  active-low write enable
- sram_wmask0  out  NUM_WMASKS  byte mask
- sram_addr0  out  ADDR_W  address
- sram_din0  out  DATA_W  write data
- sram_dout0  in  DATA_W  read data from macro

Behaviour:
- States: INIT, RUN.
- Reset:
  - Async rst forces state = INIT (RUN if INIT_EN=0), init_cnt = 0, last_grant = 1 (req0 wins first tie), rsp0_valid = rsp1_valid = 0, resp_owner/resp_is_read = 0.
  - SRAM outputs are combinational from state; during reset they are idle: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
- INIT:
  - Each cycle: csb0=0, web0=0, wmask0=all-ones, addr0=init_cnt, din0=0; init_cnt increments.
  - After the write at addr 255, state -> RUN; 256 cycles total. init_done rises in the first RUN cycle.
  - Both reqN_ready = 0 throughout INIT.
  - Reset asserted mid-INIT restarts the fill from addr 0.
- RUN, arbitration (combinational, single grant per cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant goes to !last_grant.
  - last_grant updates only on a handshake.
  - reqN_ready = RUN && grant==N. Ready may depend on valid; valid must not depend on ready (requester rule).
  - A requester holding valid is granted within 2 cycles.
- SRAM drive:
  - Granted request is driven onto sram_* in the same cycle: csb0=0, web0=!we, wmask0=wmask, addr0, din0.
  - The macro samples these on the posedge ending the cycle.
  - No grant: csb0=1, other pins 0.
- Response:
  - Handshake in cycle T -> rspN_valid = 1 in cycle T+1 for the granting requester only, for both reads and writes.
  - rspN_rdata = sram_dout0 for reads (macro data is valid before the T+1 posedge); 0 for writes and when rspN_valid = 0.
  - Back-to-back handshakes give back-to-back responses.
  - No response backpressure: requesters must accept rsp every cycle.
- Ordering and hazards:
  - Write to addr A in T followed by a read of A in T+1 returns the new data (the macro writes on the negedge of T's sample cycle).
  - Port-1 read/write collisions are the integrator's responsibility.
- Reset mid-RUN: any pending response is dropped (rspN_valid = 0).

Decomposition:
- sram_ctrl_pkg: ADDR_W/DATA_W/NUM_WMASKS constants, RAM_DEPTH = 256, state enum {INIT, RUN}.
- Sub-module rr_arb2: 2-input round-robin arbiter; inputs req[1:0], accept; outputs grant one-hot and registered last_grant; async reset.
- Top holds the FSM, init counter, response registers and SRAM mux.

Test Plan:
- Reset, INIT_EN=1 -> exactly 256 cycles of csb0=0/web0=0/wmask0=4'hF with addr 0..255 and din=0; init_done rises on cycle 257; a read of addr 0x7F then returns 32'h0.
- req0 write addr 0x10 data 32'hDEADBEEF mask 4'hF, then req0 read 0x10 next cycle -> rsp0_valid pulses twice; second rsp0_rdata = 32'hDEADBEEF.
- Byte mask: write 0x20 = 32'h11223344 mask 4'hF, then write 32'hAABBCCDD mask 4'b0101, read -> 32'h11BB33DD.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each rspN_valid pulses only on its own T+1.
- Only req1 valid 4 cycles -> req1_ready high every cycle, req0_ready 0; rsp1_valid high cycles 2-5.
- Assert rst at init_cnt=100 and release -> fill restarts at addr 0; init_done stays 0 for a further 256 cycles; rsp valids are 0 after reset.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, depth and controller state encoding for the port-0 SRAM arbiter.
// Pure declarations: no latency and no backpressure of its own.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W     = 8;
  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_W / 8;
  localparam int RAM_DEPTH       = 256;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, and the last winner is registered on accept.
// Zero-cycle grant; a loser holding its request wins on the next contested cycle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to 1 so that req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares SRAM RW port 0 between two requesters with round-robin arbitration; an optional zero-fill runs after reset.
// The response follows one cycle after the handshake; ready is withheld during fill and from the losing requester.
module sram_port0_arbiter #(
  parameter int ADDR_W     = sram_ctrl_pkg::SRAM_ADDR_W,
  parameter int DATA_W     = sram_ctrl_pkg::SRAM_DATA_W,
  parameter int NUM_WMASKS = sram_ctrl_pkg::SRAM_NUM_WMASKS,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [NUM_WMASKS-1:0] req1_wmask,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  input  logic [DATA_W-1:0]     sram_dout0
);

  import sram_ctrl_pkg::*;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                run;
  logic [1:0]          grant;
  logic                last_grant;
  logic                rsp_pend_q;
  logic                resp_is_read_q;

  assign run = (state_q == RUN);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({req1_valid, req0_valid} & {2{run}}),
    .accept     (|grant),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign init_done  = run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT_EN ? INIT : RUN;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (!rst) begin
      case (state_q)
        INIT: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = init_cnt_q;
          init_cnt_d  = init_cnt_q + 1'b1;
          if (init_cnt_q == ADDR_W'(RAM_DEPTH - 1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          sram_web0 = 1'b0;
          if (grant[0]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~req0_we;
            sram_wmask0 = req0_wmask;
            sram_addr0  = req0_addr;
            sram_din0   = req0_wdata;
          end else if (grant[1]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~req1_we;
            sram_wmask0 = req1_wmask;
            sram_addr0  = req1_addr;
            sram_din0   = req1_wdata;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend_q     <= 1'b0;
      resp_is_read_q <= 1'b0;
    end else begin
      rsp_pend_q <= |grant;
      if (|grant) begin
        resp_is_read_q <= grant[1] ? ~req1_we : ~req0_we;
      end
    end
  end

  // last_grant already records who won the most recent handshake, so it names the response owner.
  assign rsp0_valid = rsp_pend_q & ~last_grant;
  assign rsp1_valid = rsp_pend_q &  last_grant;
  assign rsp0_rdata = (rsp0_valid && resp_is_read_q) ? sram_dout0 : '0;
  assign rsp1_rdata = (rsp1_valid && resp_is_read_q) ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: behavioural SRAM macro, response scoreboard and per-scenario tasks.
module tb_sram_port0_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done;
  logic        req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
  logic [3:0]  req0_wmask = '0;
  logic [7:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
  logic [3:0]  req1_wmask = '0;
  logic [7:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];

  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  always #5 clk = ~clk;

  sram_port0_arbiter dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Macro model: samples on posedge, read data appears in the following cycle.
  initial for (int i = 0; i < 256; i++) sram_mem[i] = $urandom;
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram_mem[sram_addr0] <= merge(sram_mem[sram_addr0], sram_din0, sram_wmask0);
      else            sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  // Scoreboard: pop/compare responses, flag missing ones, then record this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid || rsp1_valid) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b, want none", rsp0_valid, rsp1_valid);
        end else begin
          e = sb_q.pop_front();
          if (rsp0_valid === rsp1_valid || rsp1_valid !== e.owner ||
              (rsp1_valid ? rsp1_rdata : rsp0_rdata) !== e.data) begin
            miscompares++;
            $display("FAIL rsp_data: got owner=%b rdata=%h, want owner=%b rdata=%h",
                     rsp1_valid, rsp1_valid ? rsp1_rdata : rsp0_rdata, e.owner, e.data);
          end
        end
      end
      vectors++;
      if ((!rsp0_valid && rsp0_rdata !== 32'h0) || (!rsp1_valid && rsp1_rdata !== 32'h0)) begin
        miscompares++;
        $display("FAIL rdata_idle: got %h/%h, want 0 when not valid", rsp0_rdata, rsp1_rdata);
      end
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_missing: got no response at cycle %0d, want owner=%b", cyc, sb_q[0].owner);
        void'(sb_q.pop_front());
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back('{1'b0, req0_we ? 32'h0 : ref_mem[req0_addr], cyc + 1});
        if (req0_we) ref_mem[req0_addr] = merge(ref_mem[req0_addr], req0_wdata, req0_wmask);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back('{1'b1, req1_we ? 32'h0 : ref_mem[req1_addr], cyc + 1});
        if (req1_we) ref_mem[req1_addr] = merge(ref_mem[req1_addr], req1_wdata, req1_wmask);
      end
      cyc++;
    end
  end

  task automatic set_req(input int n, input bit v, input bit we, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_wmask = m; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_wmask = m; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    vectors++;
    if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, init_done, rsp0_valid, rsp1_valid}
        !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_idle: got csb=%b web=%b mask=%h addr=%h din=%h done=%b rsp=%b%b, want 1 1 0 0 0 0 00",
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, init_done, rsp1_valid, rsp0_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      vectors++;
      if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, init_done, req0_ready, req1_ready}
          !== {1'b0, 1'b0, 4'hF, 8'(i), 32'h0, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL init_fill[%0d]: got csb=%b web=%b mask=%h addr=%h din=%h done=%b rdy=%b%b, want 0 0 f %h 0 0 00",
                 i, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, init_done,
                 req1_ready, req0_ready, 8'(i));
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || sram_csb0 !== 1'b1) begin
      miscompares++;
      $display("FAIL init_done: got done=%b csb=%b, want done=1 csb=1", init_done, sram_csb0);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h7F, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL read_after_fill: got valid=%b rdata=%h, want 1 00000000", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ready: got rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0 || req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_rsp: got valid=%b rdata=%h rdy=%b, want 1 00000000 1", rsp0_valid, rsp0_rdata, req0_ready);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL raw_read: got valid=%b rdata=%h, want 1 deadbeef", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_byte_mask();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h20, 32'h11223344);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h11BB33DD) begin
      miscompares++;
      $display("FAIL byte_mask: got valid=%b rdata=%h, want 1 11bb33dd", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_only_req1();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b1, 4'hF, 8'(8'h30 + k), 32'hC0DE0000 + 32'(k));
      @(negedge clk);
      vectors++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || rsp1_valid !== (k >= 2)) begin
        miscompares++;
        $display("FAIL only_req1[%0d]: got rdy1=%b rdy0=%b rsp1=%b, want 1 0 %b",
                 k, req1_ready, req0_ready, rsp1_valid, k >= 2);
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (rsp1_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL only_req1_tail: got rsp1=%b, want 1", rsp1_valid);
    end
    @(negedge clk);
    vectors++;
    if (rsp1_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL only_req1_end: got rsp1=%b, want 0", rsp1_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g, prev_g;
    prev_g = 2'b00;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== exp_g || {rsp1_valid, rsp0_valid} !== prev_g) begin
        miscompares++;
        $display("FAIL rr_cycle[%0d]: got grant=%b rsp=%b, want grant=%b rsp=%b",
                 i, {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid}, exp_g, prev_g);
      end
      prev_g = exp_g;
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if ({rsp1_valid, rsp0_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_tail: got rsp=%b, want 10", {rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_rst_mid_init();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    idle();
    #1;
    vectors++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || sram_csb0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drop_rsp: got rsp=%b%b csb=%b, want 00 1", rsp1_valid, rsp0_valid, sram_csb0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      vectors++;
      if (sram_csb0 !== 1'b0 || sram_addr0 !== 8'(i) || init_done !== 1'b0) begin
        miscompares++;
        $display("FAIL refill1[%0d]: got csb=%b addr=%h done=%b, want 0 %h 0", i, sram_csb0, sram_addr0, init_done, 8'(i));
      end
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (sram_csb0 !== 1'b1 || init_done !== 1'b0 || rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_init: got csb=%b done=%b rsp0=%b, want 1 0 0", sram_csb0, init_done, rsp0_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      vectors++;
      if (sram_csb0 !== 1'b0 || sram_addr0 !== 8'(i) || init_done !== 1'b0 ||
          rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL refill2[%0d]: got csb=%b addr=%h done=%b rsp=%b%b, want 0 %h 0 00",
                 i, sram_csb0, sram_addr0, init_done, rsp1_valid, rsp0_valid, 8'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL refill_done: got done=%b, want 1", init_done);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL refill_read: got valid=%b rdata=%h, want 1 00000000", rsp0_valid, rsp0_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_only_req1();
    test_back_to_back();
    test_rst_mid_init();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
